// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: icache request/response, branch redirect, decoder handshake, status and counters.
interface fetch_unit_if;
    logic        ic_en;
    logic [15:0] ic_addr;
    logic [15:0] ic_ir;
    logic        br_valid;
    logic [15:0] br_target;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        halted;
    logic [15:0] perf_issue_cnt;
    logic [15:0] perf_stall_cnt;

    modport master (
        output ic_en, ic_addr, inst_valid, inst_data, inst_pc, halted,
               perf_issue_cnt, perf_stall_cnt,
        input  ic_ir, br_valid, br_target, inst_ready
    );

    modport slave (
        input  ic_en, ic_addr, inst_valid, inst_data, inst_pc, halted,
               perf_issue_cnt, perf_stall_cnt,
        output ic_ir, br_valid, br_target, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: issues icache reads, buffers {pc,instr}, hands off on valid/ready; instr visible 2 cycles after issue.
// Issue throttles on buffer+inflight occupancy; hlt drains then idles; FETCH_PERF_EN adds saturating issue/stall counters.
module fetch_unit #(
    parameter int          DEPTH      = 2,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [4:0]  HLT_OPCODE = 5'b11111
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master fif
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = 3;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [15:0]   infl_pc_q, infl_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          halted_q, halted_d;
    logic [15:0]   buf_pc_q [DEPTH];
    logic [15:0]   buf_ir_q [DEPTH];

    logic          inst_valid;
    logic          pop;
    logic          issue;
    logic          capture;
    logic          is_hlt;
    logic          wr_en;
    logic [CW-1:0] occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign inst_valid = (count_q != '0) && (state_q != ST_HALTED);
    assign pop        = inst_valid && fif.inst_ready;
    assign capture    = inflight_q;
    assign is_hlt     = capture && (fif.ic_ir[15:11] == HLT_OPCODE);

    // Room is judged after this cycle's pop, so a full pipe with a consuming decoder keeps issuing.
    assign occ   = count_q + CW'(inflight_q) - CW'(pop);
    assign issue = rst_n && (state_q == ST_RUN) && !fif.br_valid && (occ < CW'(DEPTH));

    assign fif.ic_en      = issue;
    assign fif.ic_addr    = fetch_pc_q;
    assign fif.inst_valid = inst_valid;
    assign fif.inst_data  = buf_ir_q[rd_ptr_q];
    assign fif.inst_pc    = buf_pc_q[rd_ptr_q];
    assign fif.halted     = halted_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        infl_pc_d  = infl_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        halted_d   = halted_q;
        wr_en      = 1'b0;
        if (fif.br_valid) begin
            state_d    = ST_RUN;
            fetch_pc_d = fif.br_target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            halted_d   = 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 16'd1;
                inflight_d = 1'b1;
                infl_pc_d  = fetch_pc_q;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (capture) begin
                wr_en    = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CW'(capture) - CW'(pop);
            // The fetch issued alongside the hlt capture is dropped; restart point is just past the hlt.
            if (is_hlt && (state_q == ST_RUN)) begin
                state_d    = ST_DRAIN;
                inflight_d = 1'b0;
                fetch_pc_d = infl_pc_q + 16'd1;
            end
            if ((state_q == ST_DRAIN) && pop && (count_q == CW'(1))) begin
                state_d  = ST_HALTED;
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            infl_pc_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            halted_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i] <= '0;
                buf_ir_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            infl_pc_q  <= infl_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            halted_q   <= halted_d;
            if (wr_en) begin
                buf_pc_q[wr_ptr_q] <= infl_pc_q;
                buf_ir_q[wr_ptr_q] <= fif.ic_ir;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_issue_q;
    logic [15:0] perf_stall_q;
    logic        stall;

    assign stall = inst_valid && !fif.inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue && (perf_issue_q != 16'hFFFF)) begin
                perf_issue_q <= perf_issue_q + 16'd1;
            end
            if (stall && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign fif.perf_issue_cnt = perf_issue_q;
    assign fif.perf_stall_cnt = perf_stall_q;
`else
    assign fif.perf_issue_cnt = 16'h0000;
    assign fif.perf_stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an icache model and a {pc,instr} scoreboard checked at every decoder pop.
module tb_fetch_unit;
    localparam int          DEPTH  = 2;
    localparam logic [15:0] HLT_PC = 16'h0029;

    logic clk;
    logic rst_n;
    fetch_unit_if fif ();

    fetch_unit #(
        .DEPTH      (DEPTH),
        .RESET_PC   (16'h0000),
        .HLT_OPCODE (5'b11111)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic        skip_next   = 1'b0;
    logic        stall_prev  = 1'b0;
    logic        br_prev     = 1'b0;
    logic [15:0] held_pc     = '0;
    logic [15:0] held_data   = '0;
    logic [15:0] last_issued = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == HLT_PC) return 16'hF800;
        return {1'b0, a[14:0]} ^ 16'h0405;
    endfunction

    // icache: registered read, data valid the cycle after en
    always @(posedge clk) begin
        if (fif.ic_en === 1'b1) fif.ic_ir <= mem_word(fif.ic_addr);
    end

    always @(negedge clk) begin
        logic [31:0] e;
        logic        skip_now;
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            skip_next  = 1'b0;
            stall_prev = 1'b0;
            br_prev    = 1'b0;
        end else begin
            if (stall_prev && !br_prev) begin
                checks++;
                assert (fif.inst_valid === 1'b1 && fif.inst_pc === held_pc && fif.inst_data === held_data)
                else begin
                    errors++;
                    $error("FAIL hold: observed v=%b pc=%h d=%h expected v=1 pc=%h d=%h",
                           fif.inst_valid, fif.inst_pc, fif.inst_data, held_pc, held_data);
                end
            end
            if (fif.inst_valid === 1'b1 && fif.inst_ready === 1'b1) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
                assert ({fif.inst_pc, fif.inst_data} === e)
                else begin
                    errors++;
                    $error("FAIL pop: observed pc/instr=%h expected=%h", {fif.inst_pc, fif.inst_data}, e);
                end
            end
            if (fif.br_valid === 1'b1) exp_q.delete();
            skip_now = 1'b0;
            if (fif.ic_en === 1'b1) begin
                last_issued = fif.ic_addr;
                if (!skip_next) exp_q.push_back({fif.ic_addr, mem_word(fif.ic_addr)});
                skip_now = (mem_word(fif.ic_addr) == 16'hF800);
            end
            skip_next = skip_now;
            checks++;
            assert (exp_q.size() <= DEPTH)
            else begin
                errors++;
                $error("FAIL overflow: observed outstanding=%0d expected<=%0d", exp_q.size(), DEPTH);
            end
            stall_prev = (fif.inst_valid === 1'b1) && (fif.inst_ready === 1'b0);
            held_pc    = fif.inst_pc;
            held_data  = fif.inst_data;
            br_prev    = (fif.br_valid === 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rdy, input logic br, input logic [15:0] tgt);
        fif.inst_ready = rdy;
        fif.br_valid   = br;
        fif.br_target  = tgt;
        #1;
    endtask

    logic [15:0] exp_issue;
    logic [15:0] exp_stall;

    initial begin
        int found;
        int en_cnt;
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 16'h0000);
        repeat (3) tick();
        #1;
        chk("rst_ic_en", {31'd0, fif.ic_en}, 32'd0);
        chk("rst_ic_addr", {16'd0, fif.ic_addr}, 32'h0000);
        chk("rst_valid", {31'd0, fif.inst_valid}, 32'd0);
        chk("rst_data", {16'd0, fif.inst_data}, 32'h0000);
        chk("rst_pc", {16'd0, fif.inst_pc}, 32'h0000);
        chk("rst_halted", {31'd0, fif.halted}, 32'd0);
        chk("rst_perf_issue", {16'd0, fif.perf_issue_cnt}, 32'd0);
        chk("rst_perf_stall", {16'd0, fif.perf_stall_cnt}, 32'd0);

        // release: first issue at address 0 in the release cycle
        rst_n = 1'b1;
        #1;
        chk("c0_ic_en", {31'd0, fif.ic_en}, 32'd1);
        chk("c0_ic_addr", {16'd0, fif.ic_addr}, 32'h0000);
        for (int k = 1; k <= 9; k++) begin
            tick();
            set_in(1'b1, 1'b0, 16'h0000);
            chk("seq_ic_addr", {16'd0, fif.ic_addr}, 32'(k));
            chk("seq_ic_en", {31'd0, fif.ic_en}, 32'd1);
            if (k == 1) chk("c1_valid", {31'd0, fif.inst_valid}, 32'd0);
            if (k == 2) chk("first_data", {16'd0, fif.inst_data}, 32'h0405);
            if (k >= 2) chk("seq_inst_pc", {16'd0, fif.inst_pc}, 32'(k - 2));
        end

        // three stall cycles starting at C10
`ifdef FETCH_PERF_EN
        exp_issue = 16'd10;
        exp_stall = 16'd3;
`else
        exp_issue = 16'd0;
        exp_stall = 16'd0;
`endif
        tick();
        set_in(1'b0, 1'b0, 16'h0000);
        chk("perf_issue_10", {16'd0, fif.perf_issue_cnt}, {16'd0, exp_issue});
        chk("stall_ic_en", {31'd0, fif.ic_en}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000);
            chk("stall_head_pc", {16'd0, fif.inst_pc}, 32'h0008);
            chk("stall_no_issue", {31'd0, fif.ic_en}, 32'd0);
        end
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("perf_stall_3", {16'd0, fif.perf_stall_cnt}, {16'd0, exp_stall});
        chk("perf_issue_hold", {16'd0, fif.perf_issue_cnt}, {16'd0, exp_issue});
        chk("resume_ic_en", {31'd0, fif.ic_en}, 32'd1);
        chk("resume_ic_addr", {16'd0, fif.ic_addr}, 32'h000A);
        chk("resume_pc", {16'd0, fif.inst_pc}, 32'h0008);
        repeat (3) begin
            tick();
            set_in(1'b1, 1'b0, 16'h0000);
        end

        // redirect with the pipe full (one buffered, one in flight)
        tick();
        set_in(1'b0, 1'b1, 16'h0016);
        chk("br_ic_en", {31'd0, fif.ic_en}, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("br1_valid", {31'd0, fif.inst_valid}, 32'd0);
        chk("br1_ic_en", {31'd0, fif.ic_en}, 32'd1);
        chk("br1_ic_addr", {16'd0, fif.ic_addr}, 32'h0016);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("br2_valid", {31'd0, fif.inst_valid}, 32'd0);
        chk("br2_ic_addr", {16'd0, fif.ic_addr}, 32'h0017);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("br3_valid", {31'd0, fif.inst_valid}, 32'd1);
        chk("br3_pc", {16'd0, fif.inst_pc}, 32'h0016);
        chk("br3_data", {16'd0, fif.inst_data}, {16'd0, mem_word(16'h0016)});

        // run until the hlt reaches the head
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            tick();
            set_in(1'b1, 1'b0, 16'h0000);
            if (fif.inst_valid === 1'b1 && fif.inst_pc === HLT_PC) found = 1;
        end
        chk("hlt_seen", 32'(found), 32'd1);
        chk("hlt_data", {16'd0, fif.inst_data}, 32'hF800);
        chk("hlt_not_halted", {31'd0, fif.halted}, 32'd0);
        chk("hlt_drain_ic_en", {31'd0, fif.ic_en}, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("halted", {31'd0, fif.halted}, 32'd1);
        chk("halted_valid", {31'd0, fif.inst_valid}, 32'd0);
        chk("last_issued", {16'd0, last_issued}, 32'h002A);
        en_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            set_in(1'b1, 1'b0, 16'h0000);
            if (fif.ic_en !== 1'b0) en_cnt++;
        end
        chk("halted_idle_20", 32'(en_cnt), 32'd0);
        chk("halted_sticky", {31'd0, fif.halted}, 32'd1);

        // redirect out of HALTED just below the wrap point
        set_in(1'b1, 1'b1, 16'hFFFE);
        chk("brh_ic_en", {31'd0, fif.ic_en}, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("brh_halted", {31'd0, fif.halted}, 32'd0);
        chk("brh_ic_en1", {31'd0, fif.ic_en}, 32'd1);
        chk("brh_ic_addr", {16'd0, fif.ic_addr}, 32'hFFFE);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("wrap_ffff", {16'd0, fif.ic_addr}, 32'hFFFF);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("wrap_0000", {16'd0, fif.ic_addr}, 32'h0000);
        chk("wrap_head", {16'd0, fif.inst_pc}, 32'hFFFE);
        repeat (3) begin
            tick();
            set_in(1'b1, 1'b0, 16'h0000);
        end

        // reset while a fetch is in flight
        rst_n = 1'b0;
        #1;
        chk("mrst_ic_en", {31'd0, fif.ic_en}, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("mrst_valid", {31'd0, fif.inst_valid}, 32'd0);
        chk("mrst_ic_addr", {16'd0, fif.ic_addr}, 32'h0000);
        chk("mrst_pc", {16'd0, fif.inst_pc}, 32'h0000);
        chk("mrst_data", {16'd0, fif.inst_data}, 32'h0000);
        chk("mrst_perf_issue", {16'd0, fif.perf_issue_cnt}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mrel_ic_en", {31'd0, fif.ic_en}, 32'd1);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("mrel_valid1", {31'd0, fif.inst_valid}, 32'd0);
        tick();
        set_in(1'b1, 1'b0, 16'h0000);
        chk("mrel_valid2", {31'd0, fif.inst_valid}, 32'd1);
        chk("mrel_data", {16'd0, fif.inst_data}, 32'h0405);
        chk("mrel_pc", {16'd0, fif.inst_pc}, 32'h0000);
        repeat (4) begin
            tick();
            set_in(1'b1, 1'b0, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
